// File: rtl/micro_sequencer.sv
// micro_sequencer
//   Micro-PC register and next-state selector for the microprogrammed MIPS
//   control unit. Each non-stalled clock the micro-state advances to a target
//   chosen by the sequencing field. The target can be fetch, increment,
//   dispatch 1 or dispatch 2. Microinstructions flagged loop_en hold their
//   state for LOOP_CYCLES cycles. These are used for mult/div/madd/msub.
//   A dispatch through an undefined table entry traps to TRAP_STATE and
//   raises the sticky illegal_op flag.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   addr_ctl       00 fetch, 01 increment, 10 dispatch 1, 11 dispatch 2
//   next_state_DT1 dispatch table 1 target;  dt1_valid marks a defined entry
//   next_state_DT2 dispatch table 2 target;  dt2_valid marks a defined entry
//   loop_en        hold the current state for LOOP_CYCLES non-stalled cycles
//   stall          freezes all sequencer state (highest priority)
//   state          current micro-state (micro-PC)
//   busy           loop hold in progress
//   illegal_op     sticky: an undefined dispatch occurred
//   retire         one-cycle pulse after a move into FETCH_STATE
module micro_sequencer #(
    parameter int unsigned SW          = 5,
    parameter int unsigned FETCH_STATE = 0,
    parameter int unsigned TRAP_STATE  = 31,
    parameter int unsigned LOOP_CYCLES = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    addr_ctl,
    input  logic [SW-1:0] next_state_DT1,
    input  logic          dt1_valid,
    input  logic [SW-1:0] next_state_DT2,
    input  logic          dt2_valid,
    input  logic          loop_en,
    input  logic          stall,
    output logic [SW-1:0] state,
    output logic          busy,
    output logic          illegal_op,
    output logic          retire
);

    localparam logic [SW-1:0] FETCH   = SW'(FETCH_STATE);
    localparam logic [SW-1:0] TRAP    = SW'(TRAP_STATE);
    localparam logic          LOOP_ON = (LOOP_CYCLES > 1);
    // Counter holds at most LOOP_CYCLES-2; the first hold cycle is spent loading it.
    localparam int unsigned   CW      = (LOOP_CYCLES > 2) ? $clog2(LOOP_CYCLES - 1) : 1;
    localparam logic [CW-1:0] LOAD    = CW'(LOOP_CYCLES - 2);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } mode_t;

    mode_t         mode;
    logic [CW-1:0] count;

    logic [SW-1:0] target;
    logic          trap_dispatch;
    logic          adv_retire;
    logic          adv_illegal;

    always_comb begin
        target        = FETCH;
        trap_dispatch = 1'b0;
        case (addr_ctl)
            2'b00: target = FETCH;
            2'b01: target = state + SW'(1);
            2'b10: begin
                target        = dt1_valid ? next_state_DT1 : TRAP;
                trap_dispatch = ~dt1_valid;
            end
            default: begin
                target        = dt2_valid ? next_state_DT2 : TRAP;
                trap_dispatch = ~dt2_valid;
            end
        endcase
    end

    // Side effects of loading target into state.
    // The trap set takes priority over the fetch clear.
    always_comb begin
        adv_retire  = (target == FETCH) && (state != FETCH);
        adv_illegal = illegal_op;
        if (trap_dispatch) begin
            adv_illegal = 1'b1;
        end else if (target == FETCH) begin
            adv_illegal = 1'b0;
        end
    end

    assign busy = (mode == HOLD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            mode       <= RUN;
            count      <= '0;
            illegal_op <= 1'b0;
            retire     <= 1'b0;
        end else if (stall) begin
            retire <= 1'b0;
        end else begin
            case (mode)
                RUN: begin
                    if (loop_en && LOOP_ON) begin
                        mode   <= HOLD;
                        count  <= LOAD;
                        retire <= 1'b0;
                    end else begin
                        state      <= target;
                        retire     <= adv_retire;
                        illegal_op <= adv_illegal;
                    end
                end
                HOLD: begin
                    if (count != '0) begin
                        count  <= count - CW'(1);
                        retire <= 1'b0;
                    end else begin
                        mode       <= RUN;
                        state      <= target;
                        retire     <= adv_retire;
                        illegal_op <= adv_illegal;
                    end
                end
                default: mode <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
module tb_micro_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] addr_ctl;
    logic [4:0] next_state_DT1;
    logic       dt1_valid;
    logic [4:0] next_state_DT2;
    logic       dt2_valid;
    logic       loop_en;
    logic       stall;
    logic [4:0] state;
    logic       busy;
    logic       illegal_op;
    logic       retire;

    int total = 0;
    int bad   = 0;

    micro_sequencer #(
        .SW(5),
        .FETCH_STATE(0),
        .TRAP_STATE(31),
        .LOOP_CYCLES(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .addr_ctl(addr_ctl),
        .next_state_DT1(next_state_DT1),
        .dt1_valid(dt1_valid),
        .next_state_DT2(next_state_DT2),
        .dt2_valid(dt2_valid),
        .loop_en(loop_en),
        .stall(stall),
        .state(state),
        .busy(busy),
        .illegal_op(illegal_op),
        .retire(retire)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; addr_ctl = 2'b00; next_state_DT1 = '0; dt1_valid = 1'b0;
        next_state_DT2 = '0; dt2_valid = 1'b0; loop_en = 1'b0; stall = 1'b0;
        #3;
        chk("rst_state", state, 0);
        chk("rst_busy", busy, 0);
        chk("rst_illegal", illegal_op, 0);
        chk("rst_retire", retire, 0);
        step();
        reset = 1'b0;

        // Increment through the full space and wrap: 1..31,0,1
        addr_ctl = 2'b01;
        for (int i = 1; i <= 33; i++) begin
            step();
            chk("inc_state", state, i % 32);
            chk("inc_retire", retire, (i == 32) ? 1 : 0);
            chk("inc_illegal", illegal_op, 0);
        end
        step(); step(); step();
        chk("inc_pre_reset", state, 4);

        // Asynchronous reset mid-sequence, checked between clock edges
        reset = 1'b1;
        #2;
        chk("async_rst_state", state, 0);
        #1;
        reset = 1'b0;
        step();
        chk("after_rst_inc", state, 1);

        // Dispatch 2 valid, then undefined dispatch 1 traps
        addr_ctl = 2'b11; dt2_valid = 1'b1; next_state_DT2 = 5'd21;
        step();
        chk("dt2_state", state, 21);
        chk("dt2_illegal", illegal_op, 0);
        addr_ctl = 2'b10; dt1_valid = 1'b0; next_state_DT1 = 5'd5;
        step();
        chk("trap_state", state, 31);
        chk("trap_illegal", illegal_op, 1);
        chk("trap_retire", retire, 0);
        addr_ctl = 2'b00;
        step();
        chk("fetch_state", state, 0);
        chk("fetch_illegal_clr", illegal_op, 0);
        chk("fetch_retire", retire, 1);
        step();
        chk("fetch_hold_state", state, 0);
        chk("fetch_hold_retire", retire, 0);

        // Loop hold: 32 cycles, loop_en changes during the hold are ignored
        addr_ctl = 2'b10; dt1_valid = 1'b1; next_state_DT1 = 5'd20;
        step();
        chk("dt1_state", state, 20);
        addr_ctl = 2'b00; loop_en = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            step();
            if (e == 1) loop_en = 1'b0;
            chk("loop_state", state, (e < 32) ? 20 : 0);
            chk("loop_busy", busy, (e < 32) ? 1 : 0);
            chk("loop_retire", retire, (e < 32) ? 0 : 1);
        end
        step();
        chk("loop_retire_once", retire, 0);

        // Loop hold with a 5-edge stall at edge 10: exit on edge 37
        addr_ctl = 2'b10; next_state_DT1 = 5'd20;
        step();
        addr_ctl = 2'b00; loop_en = 1'b1;
        for (int e = 1; e <= 37; e++) begin
            step();
            loop_en = 1'b0;
            if (e == 9) stall = 1'b1;
            if (e == 14) stall = 1'b0;
            chk("sloop_state", state, (e < 37) ? 20 : 0);
            chk("sloop_busy", busy, (e < 37) ? 1 : 0);
        end
        chk("sloop_retire", retire, 1);

        // Stall blocks a pending dispatch 2 until released
        addr_ctl = 2'b01;
        step(); step(); step();
        chk("pre_stall_state", state, 3);
        addr_ctl = 2'b11; dt2_valid = 1'b1; next_state_DT2 = 5'd9; stall = 1'b1;
        step();
        chk("stall_state", state, 3);
        chk("stall_retire", retire, 0);
        step();
        chk("stall_state2", state, 3);
        stall = 1'b0;
        step();
        chk("unstall_dispatch", state, 9);

        // Stall freezes illegal_op, and a fetch while stalled does not clear it
        addr_ctl = 2'b11; dt2_valid = 1'b0;
        step();
        chk("trap2_illegal", illegal_op, 1);
        addr_ctl = 2'b00; stall = 1'b1;
        step();
        chk("stall_illegal_hold", illegal_op, 1);
        chk("stall_trap_state", state, 31);
        stall = 1'b0;
        step();
        chk("clr_illegal", illegal_op, 0);

        // Reset in mid-loop, then a full-length loop again
        addr_ctl = 2'b10; dt1_valid = 1'b1; next_state_DT1 = 5'd20;
        step();
        addr_ctl = 2'b00; loop_en = 1'b1;
        for (int e = 1; e <= 10; e++) step();
        chk("midloop_busy", busy, 1);
        loop_en = 1'b0;
        reset = 1'b1;
        #2;
        chk("midloop_rst_state", state, 0);
        chk("midloop_rst_busy", busy, 0);
        #1;
        reset = 1'b0;
        addr_ctl = 2'b10;
        step();
        chk("restart_dt1", state, 20);
        chk("restart_idle", busy, 0);
        addr_ctl = 2'b00; loop_en = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            step();
            loop_en = 1'b0;
            chk("rloop_state", state, (e < 32) ? 20 : 0);
            chk("rloop_busy", busy, (e < 32) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Micro-PC register and next-state selector for the microprogrammed MIPS control unit.
- Consumes the combinational dispatch-table outputs (next_state_DT1, next_state_DT2) and the sequencing fields of the current microinstruction.
- Each clock, it registers the next micro-state. The micro-state addresses the control store and drives the control-signal decode.
- Adds stall hold, fixed-length iteration hold for mult/div/madd/msub states, and illegal-dispatch trapping.

Parameters:
- SW, 5, micro-state width in bits.
- FETCH_STATE, 0, micro-state for instruction fetch; also the reset state.
- TRAP_STATE, 31, micro-state entered on an undefined dispatch.
- LOOP_CYCLES, 32, total non-stalled cycles spent in a loop_en state (minimum 1).

Ports:
- clk  in  1  system clock; all registers update on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr_ctl  in  2  sequencing field: 00 fetch, 01 increment, 10 dispatch 1, 11 dispatch 2.
- next_state_DT1  in  SW  target micro-state from dispatch table 1.
- dt1_valid  in  1  high when the opcode is defined in dispatch table 1.
- next_state_DT2  in  SW  target micro-state from dispatch table 2.
- dt2_valid  in  1  high when the opcode/funct is defined in dispatch table 2.
- loop_en  in  1  microinstruction field: hold this state for LOOP_CYCLES cycles.
- stall  in  1  memory/external wait; freezes all sequencer state.
- state  out  SW  current micro-state (micro-PC).
- busy  out  1  high while a loop hold is in progress.
- illegal_op  out  1  sticky flag: an undefined dispatch occurred.
- retire  out  1  one-cycle pulse when the state moves from non-FETCH_STATE to FETCH_STATE.

Behaviour:
- Reset (asynchronous, active-high), all registers cleared immediately regardless of clk:
  - state=FETCH_STATE
  - busy=0, loop counter=0
  - illegal_op=0, retire=0
  - Reset asserted mid-loop or mid-stall aborts that operation with no residue.
- Target computation (combinational, per cycle):
  - 00 -> FETCH_STATE.
  - 01 -> state+1, modulo 2^SW (31 wraps to 0).
  - 10 -> next_state_DT1 if dt1_valid, else TRAP_STATE.
  - 11 -> next_state_DT2 if dt2_valid, else TRAP_STATE.
- Stall:
  - When stall=1: state, loop counter, busy and illegal_op hold, and retire=0.
  - stall has priority over every other input.
- Loop hold (applies to non-stalled cycles only):
  - loop_en=1, busy=0, LOOP_CYCLES>1: state holds; busy<=1; counter<=LOOP_CYCLES-2.
  - busy=1, counter!=0: state holds; counter decrements.
  - busy=1, counter==0: state<=target; busy<=0.
  - Net effect: a loop_en state occupies exactly LOOP_CYCLES non-stalled cycles. A stall inside the loop extends it 1:1.
  - loop_en is sampled only while busy=0. Changes to loop_en during a hold are ignored.
  - With LOOP_CYCLES=1, loop_en has no effect.
- Normal advance (not stalled, no hold): state<=target on every edge.
- illegal_op:
  - Set in the cycle state is loaded with TRAP_STATE because of an invalid dispatch.
  - Cleared in the cycle state is loaded with FETCH_STATE.
  - If both happen in the same cycle, set wins.
  - Reaching TRAP_STATE via increment does not set illegal_op.
- retire:
  - Registered; equals 1 for the cycle after an edge that moves state from a value other than FETCH_STATE to FETCH_STATE.
  - Holding in FETCH_STATE, or reset, gives retire=0.
- Dispatch targets are used unchecked. Any SW-bit value is legal as a target.

Test Plan:
- Reset then clk with addr_ctl=01 for 33 edges -> state 0,1,...,31,0,1; with reset asserted mid-sequence, state=0 immediately, no clk edge needed.
- addr_ctl=11, dt2_valid=1, next_state_DT2=21 at state=1 -> state=21 next edge; addr_ctl=10, dt1_valid=0 -> state=31, illegal_op=1; then addr_ctl=00 -> state=0, illegal_op=0, retire=1 for one cycle.
- State 20 with loop_en=1, addr_ctl=00, LOOP_CYCLES=32 -> state=20 and busy=1 for edges 1..31; state=0 on edge 32; busy=0; retire pulses once.
- Same loop with stall=1 for 5 cycles at edge 10 -> exit on edge 37; counter and state frozen during stall.
- stall=1 with addr_ctl=11 at state=3 -> state stays 3, retire=0; release stall -> dispatch taken on next edge.
- Reset asserted at loop count 10 -> state=0, busy=0; restart loop -> full 32 cycles again.
